onehot_enc4: RTL and testbench

ONEHOT_ENC4 -- requirements
Module: onehot_enc4

---
 rtl/onehot_enc4.sv | 139 +++++++++++++
 tb/tb_onehot_enc4.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_enc4.sv
// ---------------------------------------------------------------------------
// onehot_enc4
//
// Purpose:
//   This block encodes a 4-bit one-hot code into a 2-bit binary index.
//   Each result goes into a 2-entry FIFO with a ready/valid handshake on
//   both sides. A code that is not one-hot is still encoded: the index is
//   taken from the highest set bit, or 0 when no bit is set. Such a result
//   is flagged with out_err, and a saturating 8-bit counter tallies it.
//
// Ports:
//   clk        in   1  rising-edge clock for all state
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  upstream presents in_code this cycle
//   in_ready   out  1  block accepts in_code this cycle
//   in_code    in   4  one-hot code to encode (bit i set -> index i)
//   out_valid  out  1  out_code/out_err hold a buffered result
//   out_ready  in   1  downstream consumes the head result this cycle
//   out_code   out  2  binary index of the head result
//   out_err    out  1  head result came from a non-one-hot code
//   err_count  out  8  saturating count of accepted non-one-hot codes
//   clr_err    in   1  synchronous clear of err_count
// ---------------------------------------------------------------------------
module onehot_enc4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_code,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_code,
   output logic       out_err,
   output logic [7:0] err_count,
   input  logic       clr_err
);

   // Occupancy states of the result FIFO
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   // Encoded result is {err, index}
   function automatic logic [2:0] encode(input logic [3:0] code);
      logic [1:0] idx;
      logic       err;
      // The index always comes from the highest set bit. For a valid
      // one-hot code this is the one and only set bit.
      if (code[3])
         idx = 2'd3;
      else if (code[2])
         idx = 2'd2;
      else if (code[1])
         idx = 2'd1;
      else
         idx = 2'd0;
      case (code)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: err = 1'b0;
         default:                            err = 1'b1;
      endcase
      return {err, idx};
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [1:0] state;
   logic [2:0] enc_p0;
   logic [2:0] head_p1;
   logic [2:0] tail_p1;
   logic       accept;
   logic       pop;

   // ---- stage p0: handshake decode and combinational encode ----
   assign in_ready  = (state != FULL) && !rst;
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign enc_p0    = encode(in_code);

   // ---- stage p1: FIFO storage, head is always slot head_p1 ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         head_p1 <= '0;
         tail_p1 <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  head_p1 <= enc_p0;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  // The old head leaves while the new entry takes its place.
                  head_p1 <= enc_p0;
               end else if (accept) begin
                  tail_p1 <= enc_p0;
                  state   <= FULL;
               end else if (pop) begin
                  head_p1 <= '0;
                  state   <= EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  head_p1 <= tail_p1;
                  tail_p1 <= '0;
                  state   <= ONE;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

   // The clear and an erroneous accept can land on the same edge. In that
   // case the clear comes first and the new error is counted on top of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= (accept && enc_p0[2]) ? 8'd1 : 8'd0;
      end else if (accept && enc_p0[2]) begin
         err_count <= sat_inc(err_count);
      end
   end

   // ---- output: outputs are forced to zero when no result is held ----
   assign out_code = out_valid ? head_p1[1:0] : 2'b00;
   assign out_err  = out_valid ? head_p1[2]   : 1'b0;

endmodule

// File: tb/tb_onehot_enc4.sv
// ---------------------------------------------------------------------------
// tb_onehot_enc4
//
// Purpose:
//   Self-checking bench for onehot_enc4. The reference model holds the FIFO
//   contents as a queue of {err, index}. It counts errors with a plain
//   integer and encodes codes arithmetically.
// ---------------------------------------------------------------------------
module tb_onehot_enc4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_code;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_code;
   logic       out_err;
   logic [7:0] err_count;
   logic       clr_err;

   int         n_chk;
   int         n_fail;

   logic [2:0] mq[$];
   int         merr;

   onehot_enc4 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_code   (in_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_err   (out_err),
      .err_count (err_count),
      .clr_err   (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference encoding: a code is one-hot when exactly one bit is set.
   // The index is the position of the highest set bit.
   function automatic logic [2:0] ref_enc(input logic [3:0] c);
      int hi;
      int ones;
      hi   = 0;
      ones = 0;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) begin
            hi = i;
            ones++;
         end
      end
      return {(ones != 1), 2'(hi)};
   endfunction

   task automatic check_outputs(input string tag);
      logic [2:0] h;
      h = (mq.size() > 0) ? mq[0] : 3'b000;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
      chk({tag, ".out_code"},  32'(out_code),  32'(h[1:0]));
      chk({tag, ".out_err"},   32'(out_err),   32'(h[2]));
      chk({tag, ".err_count"}, 32'(err_count), 32'(merr));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < 2));
   endtask

   // Called just after a falling edge. It drives the inputs and crosses one
   // rising edge while the model tracks that edge. It then checks the
   // outputs at the next falling edge.
   task automatic step(input logic v, input logic [3:0] c, input logic ordy,
                       input logic clr, input string tag);
      logic acc;
      logic pp;
      logic [2:0] e;
      in_valid  = v;
      in_code   = c;
      out_ready = ordy;
      clr_err   = clr;
      @(posedge clk);
      acc = v && (mq.size() < 2);
      pp  = ordy && (mq.size() > 0);
      e   = ref_enc(c);
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      if (clr)
         merr = (acc && e[2]) ? 1 : 0;
      else if (acc && e[2] && merr < 255)
         merr++;
      @(negedge clk);
      check_outputs(tag);
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      merr      = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_code   = 4'b0000;
      out_ready = 1'b0;
      clr_err   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      // Outputs during reset
      chk("rst.in_ready",  32'(in_ready),  32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_code",  32'(out_code),  32'd0);
      chk("rst.out_err",   32'(out_err),   32'd0);
      chk("rst.err_count", 32'(err_count), 32'd0);
      rst = 1'b0;

      // First edge after reset accepts 0100
      step(1'b1, 4'b0100, 1'b1, 1'b0, "first");
      chk("first.code10", 32'(out_code), 32'd2);
      step(1'b0, 4'b0000, 1'b1, 1'b0, "drain0");

      // Fill to FULL, then drain in order
      step(1'b1, 4'b0001, 1'b0, 1'b0, "fill0");
      step(1'b1, 4'b1000, 1'b0, 1'b0, "fill1");
      chk("full.in_ready", 32'(in_ready), 32'd0);
      step(1'b1, 4'b0100, 1'b0, 1'b0, "full_ignore");
      step(1'b0, 4'b0000, 1'b1, 1'b0, "pop0");
      chk("pop0.code11", 32'(out_code), 32'd3);
      chk("pop0.in_ready", 32'(in_ready), 32'd1);
      step(1'b0, 4'b0000, 1'b1, 1'b0, "pop1");

      // Error codes 0000 and 1010
      step(1'b1, 4'b0000, 1'b0, 1'b0, "err0");
      step(1'b1, 4'b1010, 1'b0, 1'b0, "err1");
      step(1'b0, 4'b0000, 1'b1, 1'b0, "err_pop0");
      chk("err.code11", 32'(out_code), 32'd3);
      chk("err.cnt2",   32'(err_count), 32'd2);
      step(1'b0, 4'b0000, 1'b1, 1'b0, "err_pop1");

      // Saturation, then a clear on the same edge as an error
      for (int i = 0; i < 300; i++) step(1'b1, 4'b1111, 1'b1, 1'b0, "sat");
      chk("sat.cnt255", 32'(err_count), 32'd255);
      step(1'b1, 4'b1111, 1'b1, 1'b1, "clr_err");
      chk("clr.cnt1", 32'(err_count), 32'd1);
      step(1'b0, 4'b0000, 1'b1, 1'b0, "sat_drain");

      // Accept and pop together while in ONE
      step(1'b1, 4'b0001, 1'b0, 1'b0, "one_load");
      step(1'b1, 4'b0010, 1'b1, 1'b0, "one_swap");
      chk("swap.code01", 32'(out_code), 32'd1);
      step(1'b0, 4'b0000, 1'b1, 1'b0, "swap_pop");
      chk("swap.empty", 32'(out_valid), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), 4'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0), "rand");
      end

      // Asynchronous reset while FULL
      step(1'b0, 4'b0000, 1'b1, 1'b0, "pre_rst0");
      step(1'b0, 4'b0000, 1'b1, 1'b0, "pre_rst1");
      step(1'b1, 4'b0011, 1'b0, 1'b0, "arst_fill0");
      step(1'b1, 4'b0100, 1'b0, 1'b0, "arst_fill1");
      chk("arst.full", 32'(in_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      mq.delete();
      merr = 0;
      chk("arst.out_valid", 32'(out_valid), 32'd0);
      chk("arst.in_ready",  32'(in_ready),  32'd0);
      chk("arst.out_code",  32'(out_code),  32'd0);
      chk("arst.err_count", 32'(err_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 4'b1000, 1'b1, 1'b0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
